// File: rtl/ps2_pkg.sv
// Shared PS/2 frame constants, deframer state encoding and frame validity check.
package ps2_pkg;
  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_START      = 0;
  localparam int PS2_PAR        = 9;
  localparam int PS2_STOP       = 10;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} ps2_state_t;

  // Start low, stop high, odd parity across data plus parity bit.
  function automatic logic frame_valid(input logic [PS2_FRAME_BITS-1:0] f);
    return !f[PS2_START] && f[PS2_STOP] && (^f[PS2_PAR:1]);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead FIFO with registered head: a push is visible at dout one cycle later,
// a pop advances dout on the next cycle; push while full is dropped unless popping.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr, wptr_nxt, rptr_nxt;
  logic             do_push, do_pop;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign rptr_nxt = rptr + {{AW{1'b0}}, do_pop};
  assign wptr_nxt = wptr + {{AW{1'b0}}, do_push};

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

  // dout tracks the next head; it bypasses din when the pushed entry becomes the head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      dout <= '0;
    end else begin
      wptr <= wptr_nxt;
      rptr <= rptr_nxt;
      if (rptr_nxt != wptr_nxt)
        dout <= (do_push && rptr_nxt == wptr) ? din : mem[rptr_nxt[AW-1:0]];
    end
  end
endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 receive front end: pin sync, falling-edge detect, 11-bit deframer with timeout,
// buffering good bytes in a show-ahead FIFO; byte visible 2 cycles after the stop-bit edge.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0]    clk_sync, dat_sync;
  logic                      clk_prev, clk_s, dat_s, fall;
  ps2_state_t                state;
  logic [3:0]                bit_cnt;
  logic [IW-1:0]             idle_cnt;
  logic [PS2_FRAME_BITS-1:0] shreg, frame_nxt;
  logic                      frame_ok;
  logic                      empty, full, pop, push;

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];
  assign fall  = clk_prev && !clk_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev <= clk_s;
    end
  end

  always_comb begin
    frame_nxt = shreg;
    for (int i = 0; i < PS2_FRAME_BITS; i++)
      if (bit_cnt == 4'(i)) frame_nxt[i] = dat_s;
  end

  // Validity is judged as the stop bit arrives so frame_err/frame_ok are registered for CHECK.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      idle_cnt  <= '0;
      shreg     <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (fall) begin
            shreg   <= {{(PS2_FRAME_BITS-1){1'b0}}, dat_s};
            bit_cnt <= 4'd1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (fall) begin
            shreg    <= frame_nxt;
            bit_cnt  <= bit_cnt + 4'd1;
            idle_cnt <= '0;
            if (bit_cnt == 4'(PS2_STOP)) begin
              state     <= CHECK;
              frame_ok  <= frame_valid(frame_nxt);
              frame_err <= !frame_valid(frame_nxt);
            end
          end else if (idle_cnt == IW'(TIMEOUT_CYCLES - 1)) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            idle_cnt <= '0;
            shreg    <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        CHECK: begin
          state   <= IDLE;
          bit_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pop  = rd_en && !empty;
  assign push = frame_ok && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      overflow <= 1'b0;
    else if (frame_ok && full && !pop)
      overflow <= 1'b1;
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (shreg[8:1]),
    .dout  (data),
    .empty (empty),
    .full  (full)
  );

  assign ready = !empty;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: table of single frames plus overflow, reset and timeout sequences.
module tb_ps2_rx_fifo;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst, ps2_clk, ps2_data, rd_en;
  logic [7:0] data;
  logic       ready, overflow, frame_err;

  int total = 0, passed = 0, err_cnt = 0;
  logic       err_at_check, rdy_at_check, rdy_after, ovf_after;
  logic [7:0] data_after;

  typedef struct {
    logic [7:0] b;
    logic       bad_start;
    logic       bad_par;
    logic       bad_stop;
    logic       ok;
  } vec_t;
  vec_t vt[7];

  ps2_rx_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rd_en     (rd_en),
    .data      (data),
    .ready     (ready),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err) err_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input logic bs, input logic bp, input logic bst);
    return {~bst, (~^b) ^ bp, b, bs};
  endfunction

  // Drives nbits of frame f; on the stop bit, samples the CHECK cycle and the cycle after it.
  task automatic send_bits(input logic [10:0] f, input int nbits, input logic pop_at_check);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) begin
        repeat (4) @(posedge clk);
        #1;
        err_at_check = frame_err;
        rdy_at_check = ready;
        if (pop_at_check) rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en      = 1'b0;
        rdy_after  = ready;
        data_after = data;
        ovf_after  = overflow;
      end
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(mk(b, 1'b0, 1'b0, 1'b0), 11, 1'b0);
  endtask

  task automatic pop_expect(input string name, input logic [7:0] exp);
    @(negedge clk);
    check(name, {31'd0, ready}, 32'd1);
    check(name, {24'd0, data}, {24'd0, exp});
    rd_en = 1'b1;
    @(negedge clk) rd_en = 1'b0;
  endtask

  initial begin
    int e0;
    vt[0] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[1] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[2] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[3] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[4] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[5] = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[6] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0};

    rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", {24'd0, data}, 32'h00);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      send_bits(mk(vt[i].b, vt[i].bad_start, vt[i].bad_par, vt[i].bad_stop), 11, 1'b0);
      check($sformatf("v%0d_err", i), {31'd0, err_at_check}, {31'd0, !vt[i].ok});
      check($sformatf("v%0d_rdy_check", i), {31'd0, rdy_at_check}, 32'd0);
      check($sformatf("v%0d_rdy_after", i), {31'd0, rdy_after}, {31'd0, vt[i].ok});
      if (vt[i].ok) begin
        check($sformatf("v%0d_data_after", i), {24'd0, data_after}, {24'd0, vt[i].b});
        pop_expect($sformatf("v%0d_pop", i), vt[i].b);
      end
      check($sformatf("v%0d_empty", i), {31'd0, ready}, 32'd0);
    end
    check("err_pulse_count", err_cnt, 3);

    for (int k = 1; k <= 9; k++) send_byte(8'(k));
    check("ovf_set", {31'd0, overflow}, 32'd1);
    for (int k = 1; k <= 8; k++) pop_expect($sformatf("ovf_pop%0d", k), 8'(k));
    check("ovf_drained", {31'd0, ready}, 32'd0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    check("pre_rst_head", {24'd0, data}, 32'h11);
    send_bits(mk(8'h44, 1'b0, 1'b0, 1'b0), 4, 1'b0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_data", {24'd0, data}, 32'h00);
    check("mid_rst_ready", {31'd0, ready}, 32'd0);
    check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    check("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    e0 = err_cnt;
    send_byte(8'h1C);
    pop_expect("post_rst", 8'h1C);
    check("post_rst_empty", {31'd0, ready}, 32'd0);
    check("post_rst_no_err", err_cnt, e0);

    for (int k = 1; k <= 8; k++) send_byte(8'(k));
    check("full_ovf_clear", {31'd0, overflow}, 32'd0);
    send_bits(mk(8'h09, 1'b0, 1'b0, 1'b0), 11, 1'b1);
    check("simul_ovf_after", {31'd0, ovf_after}, 32'd0);
    check("simul_head_after", {24'd0, data_after}, 32'h02);
    for (int k = 2; k <= 9; k++) pop_expect($sformatf("simul_pop%0d", k), 8'(k));
    check("simul_drained", {31'd0, ready}, 32'd0);
    check("simul_ovf_final", {31'd0, overflow}, 32'd0);

    e0 = err_cnt;
    send_bits(mk(8'h55, 1'b0, 1'b0, 1'b0), 5, 1'b0);
    repeat (6000) @(negedge clk);
    send_byte(8'hF0);
    check("tmo_ready", {31'd0, ready}, 32'd1);
    check("tmo_data", {24'd0, data}, 32'hF0);
    check("tmo_no_err", err_cnt, e0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
